// File: rtl/vote_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : vote_monitor
//  Description : Qualifies 2-of-3 voter output, tracks voter health
//                (OK/DEGRADED/FAULT) and counts non-unanimous samples.
//  Revision    : 1.0  initial release
// ============================================================================
module vote_monitor #(
    parameter int W             = 2,
    parameter int FAIL_LIMIT    = 4,
    parameter int RECOVER_LIMIT = 8,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [W-1:0]     major,
    input  logic [1:0]       flags,
    input  logic             clear,
    output logic [W-1:0]     data_out,
    output logic             data_valid,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fault
);

    localparam int c_GOOD_W = $clog2(RECOVER_LIMIT + 1);
    localparam int c_FAIL_W = $clog2(FAIL_LIMIT + 1);
    localparam logic [c_GOOD_W-1:0] c_RECOVER = c_GOOD_W'(RECOVER_LIMIT);
    localparam logic [c_FAIL_W-1:0] c_FAIL    = c_FAIL_W'(FAIL_LIMIT);

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_DEGRADED = 2'b01,
        ST_FAULT    = 2'b10,
        ST_ILLEGAL  = 2'b11
    } state_t;

    state_t              r_state;
    logic [c_GOOD_W-1:0] r_good_run;
    logic [c_FAIL_W-1:0] r_fail_run;

    logic                w_unan;
    logic                w_none;
    logic [c_GOOD_W-1:0] w_good_next;
    logic [c_FAIL_W-1:0] w_fail_next;
    logic [CNT_W-1:0]    w_err_next;
    state_t              w_state_next;

    // flags=01 is illegal and deliberately folded into the "none" class
    assign w_unan = (flags == 2'b11);
    assign w_none = ~flags[1];

    assign w_good_next = !w_unan ? '0 :
                         (r_good_run == c_RECOVER) ? r_good_run : r_good_run + c_GOOD_W'(1);
    assign w_fail_next = !w_none ? '0 :
                         (r_fail_run == c_FAIL) ? r_fail_run : r_fail_run + c_FAIL_W'(1);
    assign w_err_next  = (!w_unan && (err_cnt != {CNT_W{1'b1}})) ? err_cnt + CNT_W'(1) : err_cnt;

    // Transition for an accepted sample, using run lengths that include it
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_OK: begin
                if (w_fail_next == c_FAIL)
                    w_state_next = ST_FAULT;
                else if (!w_unan)
                    w_state_next = ST_DEGRADED;
            end
            ST_DEGRADED: begin
                if (w_good_next == c_RECOVER)
                    w_state_next = ST_OK;
                else if (w_fail_next == c_FAIL)
                    w_state_next = ST_FAULT;
            end
            ST_FAULT:   w_state_next = ST_FAULT;
            default:    w_state_next = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_OK;
            r_good_run <= '0;
            r_fail_run <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            err_cnt    <= '0;
            fault      <= 1'b0;
        end else if (clear) begin
            r_state    <= ST_OK;
            r_good_run <= '0;
            r_fail_run <= '0;
            data_valid <= 1'b0;
            err_cnt    <= '0;
            fault      <= 1'b0;
        end else if (valid_in) begin
            r_state    <= w_state_next;
            r_good_run <= w_good_next;
            r_fail_run <= w_fail_next;
            err_cnt    <= w_err_next;
            fault      <= (w_state_next == ST_FAULT);
            if ((r_state == ST_OK || r_state == ST_DEGRADED) && !w_none) begin
                data_out   <= major;
                data_valid <= 1'b1;
            end else begin
                data_valid <= 1'b0;
            end
        end else begin
            data_valid <= 1'b0;
            if (r_state == ST_ILLEGAL) begin
                r_state <= ST_FAULT;
                fault   <= 1'b1;
            end
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_vote_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vote_monitor
//  Description : Vector table, corner sequences and random run against a
//                behavioural model for vote_monitor (CNT_W=8 and CNT_W=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vote_monitor;

    localparam int c_FL = 4;
    localparam int c_RL = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_in;
    logic       clear;
    logic [1:0] major;
    logic [1:0] flags;

    logic [1:0] data_out,   data_out4;
    logic       data_valid, data_valid4;
    logic [1:0] state,      state4;
    logic       fault,      fault4;
    logic [7:0] err_cnt;
    logic [3:0] err_cnt4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vote_monitor #(.W(2), .FAIL_LIMIT(c_FL), .RECOVER_LIMIT(c_RL), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .major(major), .flags(flags),
        .clear(clear), .data_out(data_out), .data_valid(data_valid), .state(state),
        .err_cnt(err_cnt), .fault(fault)
    );

    vote_monitor #(.W(2), .FAIL_LIMIT(c_FL), .RECOVER_LIMIT(c_RL), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .major(major), .flags(flags),
        .clear(clear), .data_out(data_out4), .data_valid(data_valid4), .state(state4),
        .err_cnt(err_cnt4), .fault(fault4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // Compare both instances against one expectation; err is unbounded count
    task automatic check_all(input string tag, input int ed, input int edv, input int es, input int ee);
        chk({tag, ".data_out"},   32'(data_out),   32'(ed));
        chk({tag, ".data_valid"}, 32'(data_valid), 32'(edv));
        chk({tag, ".state"},      32'(state),      32'(es));
        chk({tag, ".fault"},      32'(fault),      32'(es == 2));
        chk({tag, ".err_cnt"},    32'(err_cnt),    32'(sat(ee, 255)));
        chk({tag, ".data_out4"},  32'(data_out4),  32'(ed));
        chk({tag, ".state4"},     32'(state4),     32'(es));
        chk({tag, ".err_cnt4"},   32'(err_cnt4),   32'(sat(ee, 15)));
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [1:0] f, input logic c);
        valid_in = v;
        major    = m;
        flags    = f;
        clear    = c;
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    int m_state, m_good, m_fail, m_err, m_data, m_dv;

    task automatic model_reset();
        m_state = 0; m_good = 0; m_fail = 0; m_err = 0; m_data = 0; m_dv = 0;
    endtask

    task automatic model_step(input logic v, input logic [1:0] m, input logic [1:0] f, input logic c);
        bit unan, none;
        unan = (f == 2'b11);
        none = (f == 2'b00) || (f == 2'b01);
        if (c) begin
            m_state = 0; m_good = 0; m_fail = 0; m_err = 0; m_dv = 0;
        end else if (!v) begin
            m_dv = 0;
        end else begin
            if (!unan) m_err++;
            m_good = unan ? sat(m_good + 1, c_RL) : 0;
            m_fail = none ? sat(m_fail + 1, c_FL) : 0;
            if (m_state != 2 && !none) begin
                m_data = int'(m);
                m_dv   = 1;
            end else begin
                m_dv = 0;
            end
            if (m_state != 2) begin
                if (m_fail == c_FL)                      m_state = 2;
                else if (m_state == 1 && m_good == c_RL) m_state = 0;
                else if (m_state == 0 && !unan)          m_state = 1;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       v;
        logic [1:0] m;
        logic [1:0] f;
        logic       c;
        int         ed;
        int         edv;
        int         es;
        int         ee;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [1:0] m, input logic [1:0] f, input logic c,
                       input int ed, input int edv, input int es, input int ee, input int n);
        vec_t t;
        t.v = v; t.m = m; t.f = f; t.c = c; t.ed = ed; t.edv = edv; t.es = es; t.ee = ee;
        for (int i = 0; i < n; i++) vecs.push_back(t);
    endtask

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; clear = 1'b0; major = '0; flags = '0;

        // unanimous stream, then majority, then recovery
        add(1, 2'b10, 2'b11, 0,  2, 1, 0, 0, 3);
        add(1, 2'b01, 2'b10, 0,  1, 1, 1, 1, 1);
        add(1, 2'b01, 2'b11, 0,  1, 1, 1, 1, 7);
        add(1, 2'b01, 2'b11, 0,  1, 1, 0, 1, 1);
        add(0, 2'b11, 2'b00, 0,  1, 0, 0, 1, 1);
        add(0, 2'b00, 2'b00, 1,  1, 0, 0, 0, 1);
        // four none samples reach FAULT, which is sticky until clear
        add(1, 2'b11, 2'b11, 0,  3, 1, 0, 0, 1);
        add(1, 2'b00, 2'b00, 0,  3, 0, 1, 1, 1);
        add(1, 2'b00, 2'b00, 0,  3, 0, 1, 2, 1);
        add(1, 2'b00, 2'b00, 0,  3, 0, 1, 3, 1);
        add(1, 2'b00, 2'b00, 0,  3, 0, 2, 4, 1);
        add(1, 2'b10, 2'b11, 0,  3, 0, 2, 4, 10);
        add(0, 2'b00, 2'b00, 1,  3, 0, 0, 0, 1);
        // interrupted none run never faults (00 and 01 alike)
        add(1, 2'b01, 2'b00, 0,  3, 0, 1, 1, 1);
        add(1, 2'b01, 2'b00, 0,  3, 0, 1, 2, 1);
        add(1, 2'b01, 2'b00, 0,  3, 0, 1, 3, 1);
        add(1, 2'b10, 2'b10, 0,  2, 1, 1, 4, 1);
        add(1, 2'b01, 2'b00, 0,  2, 0, 1, 5, 1);
        add(1, 2'b01, 2'b00, 0,  2, 0, 1, 6, 1);
        add(1, 2'b01, 2'b00, 0,  2, 0, 1, 7, 1);
        add(0, 2'b00, 2'b00, 1,  2, 0, 0, 0, 1);
        add(1, 2'b11, 2'b01, 0,  2, 0, 1, 1, 1);
        add(1, 2'b11, 2'b01, 0,  2, 0, 1, 2, 1);
        add(1, 2'b11, 2'b01, 0,  2, 0, 1, 3, 1);
        add(1, 2'b10, 2'b10, 0,  2, 1, 1, 4, 1);
        add(1, 2'b11, 2'b01, 0,  2, 0, 1, 5, 1);
        add(1, 2'b11, 2'b01, 0,  2, 0, 1, 6, 1);
        add(1, 2'b11, 2'b01, 0,  2, 0, 1, 7, 1);

        // reset state
        #21;
        check_all("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset", 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].m, vecs[i].f, vecs[i].c);
            check_all($sformatf("vec%0d", i), vecs[i].ed, vecs[i].edv, vecs[i].es, vecs[i].ee);
        end

        // counter saturation: CNT_W=4 instance stops at 15
        drive(0, 2'b00, 2'b00, 1);
        for (int i = 0; i < 20; i++) begin
            drive(1, 2'b01, 2'b10, 0);
            chk($sformatf("sat%0d.err_cnt4", i), 32'(err_cnt4), 32'(sat(i + 1, 15)));
            chk($sformatf("sat%0d.err_cnt", i),  32'(err_cnt),  32'(i + 1));
        end

        // clear beats a valid sample in the same cycle
        drive(1, 2'b11, 2'b10, 0);
        check_all("pre_clear", 3, 1, 1, 21);
        drive(1, 2'b01, 2'b10, 1);
        check_all("clear_with_valid", 3, 0, 0, 0);

        // async reset mid-cycle while DEGRADED with a sample pending
        drive(1, 2'b10, 2'b10, 0);
        check_all("pre_async", 2, 1, 1, 1);
        valid_in = 1'b1; major = 2'b10; flags = 2'b10;
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 0, 0);
        major = 2'b01; flags = 2'b11;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("first_after_reset", 1, 1, 0, 0);

        // randomized run against the reference model
        valid_in = 1'b0; clear = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        begin
            int mode;
            logic v, c;
            logic [1:0] m, f;
            mode = 0;
            for (int i = 0; i < 3000; i++) begin
                if (i % 16 == 0) mode = int'($urandom_range(0, 2));
                v = ($urandom_range(0, 9) != 0);
                c = ($urandom_range(0, 39) == 0);
                m = 2'($urandom);
                case (mode)
                    1:       f = ($urandom_range(0, 9) != 0) ? 2'b11 : 2'($urandom);
                    2:       f = ($urandom_range(0, 9) != 0) ? {1'b0, 1'($urandom)} : 2'($urandom);
                    default: f = 2'($urandom);
                endcase
                drive(v, m, f, c);
                model_step(v, m, f, c);
                check_all($sformatf("rnd%0d", i), m_data, m_dv, m_state, m_err);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
